calc_sequencer: RTL

//  Keypad-driven control FSM for the 4x8 register bank + 2-bit-op ALU datapath. Consumes decoded key codes,

---
 rtl/calc_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Keypad-driven control FSM for the register-bank + ALU calculator datapath.
// Builds decimal operands, writes A/B/R into the bank and sequences the ALU wait.
module calc_sequencer #(
    parameter logic [1:0]  ADDR_A  = 2'd0,
    parameter logic [1:0]  ADDR_B  = 2'd1,
    parameter logic [1:0]  ADDR_R  = 2'd2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rf_wr_en,
    output logic [1:0] rf_wr_addr,
    output logic [7:0] rf_wr_data,
    output logic [1:0] rf_rd_a,
    output logic [1:0] rf_rd_b,
    output logic [1:0] alu_sel,
    output logic [7:0] acc,
    output logic [7:0] result,
    output logic [2:0] flags,
    output logic       result_valid,
    output logic       busy,
    output logic       key_drop
);

    typedef enum logic [2:0] {S_A, S_WA, S_B, S_WB, S_EXEC, S_WR, S_DONE} state_t;

    localparam logic [2:0] LAT3 = 3'(ALU_LAT);

    state_t     state, state_n;
    logic [7:0] acc_n, result_n;
    logic       ovf, ovf_n, carry, carry_n, zero, zero_n;
    logic [1:0] op, op_n;
    logic [2:0] cnt, cnt_n;

    logic        is_digit, is_op, is_enter, is_clear;
    logic [11:0] acc_x10;
    logic [3:0]  op_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_A;
            acc    <= '0;
            ovf    <= 1'b0;
            op     <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            ovf    <= ovf_n;
            op     <= op_n;
            cnt    <= cnt_n;
            result <= result_n;
            carry  <= carry_n;
            zero   <= zero_n;
        end
    end

    always_comb begin
        is_digit = (key_code <= 4'd9);
        is_op    = (key_code >= 4'hA) && (key_code <= 4'hD);
        is_enter = (key_code == 4'hE);
        is_clear = (key_code == 4'hF);
        // acc*10 + digit, wide enough to detect values above 255
        acc_x10  = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {8'd0, key_code};
        op_code  = key_code - 4'hA;
    end

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        ovf_n        = ovf;
        op_n         = op;
        cnt_n        = cnt;
        result_n     = result;
        carry_n      = carry;
        zero_n       = zero;
        rf_wr_en     = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        result_valid = 1'b0;
        busy         = 1'b0;

        case (state)
            S_A, S_B, S_DONE: begin
                if (key_valid) begin
                    if (is_clear) begin
                        acc_n   = '0;
                        ovf_n   = 1'b0;
                        op_n    = '0;
                        state_n = S_A;
                    end else if (is_digit) begin
                        if (state == S_DONE) begin
                            acc_n   = {4'd0, key_code};
                            ovf_n   = 1'b0;
                            state_n = S_A;
                        end else begin
                            acc_n = acc_x10[7:0];
                            if (acc_x10 > 12'd255) ovf_n = 1'b1;
                        end
                    end else if (is_op) begin
                        op_n = op_code[1:0];
                        if (state == S_A) begin
                            state_n = S_WA;
                        end else if (state == S_DONE) begin
                            acc_n   = result;
                            state_n = S_WA;
                        end
                    end else if (is_enter && state == S_B) begin
                        state_n = S_WB;
                    end
                end
            end
            S_WA: begin
                busy       = 1'b1;
                rf_wr_en   = 1'b1;
                rf_wr_addr = ADDR_A;
                rf_wr_data = acc;
                acc_n      = '0;
                ovf_n      = 1'b0;
                state_n    = S_B;
            end
            S_WB: begin
                busy       = 1'b1;
                rf_wr_en   = 1'b1;
                rf_wr_addr = ADDR_B;
                rf_wr_data = acc;
                cnt_n      = LAT3;
                state_n    = S_EXEC;
            end
            S_EXEC: begin
                busy  = 1'b1;
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1) state_n = S_WR;
            end
            S_WR: begin
                busy         = 1'b1;
                rf_wr_en     = 1'b1;
                rf_wr_addr   = ADDR_R;
                rf_wr_data   = alu_out;
                result_n     = alu_out;
                carry_n      = alu_carry;
                zero_n       = alu_zero;
                result_valid = 1'b1;
                acc_n        = alu_out;
                state_n      = S_DONE;
            end
            default: state_n = S_A;
        endcase
    end

    assign key_drop = key_valid && busy;
    assign rf_rd_a  = ADDR_A;
    assign rf_rd_b  = ADDR_B;
    assign alu_sel  = op;
    assign flags    = {ovf, carry, zero};

endmodule
